cache_perf_top: RTL and testbench
=================================

Name: cache_perf_top

Overview:
- Self-contained cache performance harness, the top of the cache experiment.
- A fixed internal request trace drives a direct-mapped, write-back, write-allocate data cache backed by a fixed-latency word memory.
- Three 8-bit counters report elapsed cycles, completed requests and cache hits.
- No external stimulus besides clock and reset.

Parameters:
- MEM_LATENCY, 4, cycles per memory line transfer (refill or writeback).
- CACHE_LINES, 16, number of direct-mapped lines.
- LINE_WORDS, 4, 32-bit words per line (16-byte line).
- MEM_WORDS, 256, backing memory size in words.
- TRACE_LEN, 16, number of trace entries.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- clk_count  output  8  cycles elapsed since reset release until the trace completes.
- inst_count  output  8  trace requests completed.
- hit_count  output  8  completed requests that hit.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- While rst is high:
  - all counters are 0;
  - trace pointer is 0;
  - every cache line valid=0 and dirty=0;
  - controller is in IDLE.
- Memory contents are not reset. At time zero, word i holds i*4 (byte address).
- Address decode: byte address; offset = addr[3:2], index = addr[7:4], tag = addr[31:8].
- Trace (op, byte address), entries 0..15:
  - entries 0-3: R 0x000, R 0x004, R 0x008, R 0x00C
  - entries 4-7: R 0x010, W 0x014, R 0x100, R 0x000
  - entries 8-11: R 0x110, R 0x014, R 0x018, R 0x200
  - entries 12-15: R 0x204, W 0x208, R 0x208, R 0x000
- Write data for every write = 0xA5A50000 | addr[15:0].
- Controller states:
  - IDLE: first cycle after rst falls; present entry 0.
  - LOOKUP: tag compare.
  - WRITEBACK: MEM_LATENCY cycles, writes the victim line to memory.
  - REFILL: MEM_LATENCY cycles, reads the line from memory.
  - DONE: entered after the last entry completes.
- Hit: completes in the LOOKUP cycle (1 cycle). A write hit updates the word and sets dirty.
- Clean miss (victim invalid or clean): 1 + MEM_LATENCY cycles.
- Dirty miss: 1 + 2*MEM_LATENCY cycles; writeback precedes refill.
- Completion on a miss is the last REFILL cycle. The write-allocate merge occurs in that cycle and sets dirty.
- The next entry is presented in the cycle after completion.
- clk_count:
  - increments every cycle the controller is not in DONE and rst is low, including the completion cycle of the last entry;
  - frozen in DONE.
- inst_count increments on each completion. hit_count increments on each hit completion, in the same edge.
- All counters saturate at 255; no wrap.
- Reset asserted mid-trace:
  - aborts any in-flight memory transfer;
  - clears all counters;
  - invalidates the cache; dirty data is discarded;
  - restarts the trace from entry 0 after release.
- Read data returned for loads must equal the current memory/cache value. Verification probes it hierarchically; it is not exported.
- DONE is terminal until reset.

Test Plan:
- Hold rst=1 for 10 cycles -> clk_count, inst_count, hit_count all stay 0; no memory writes.
- Release rst, run to DONE -> clk_count=56, inst_count=16, hit_count=8. Entries 0,4,6,7,9,11 are clean misses, 8 and 15 are dirty misses, the rest are hits.
- Completion timing -> inst_count=1 after cycle 5, inst_count=4 after cycle 8. A hit adds 1 cycle between completions; a dirty miss (entry 8) spans 9 cycles with a memory write of line 0x010 whose word 0x014 = 0xA5A50014.
- Data integrity -> entry 9 read returns 0xA5A50014; entry 14 read returns 0xA5A50208; entry 10 returns 0x00000018.
- Assert rst for 1 cycle during entry 8 writeback, then release -> counters clear, trace restarts; final values again 56/16/8. Entry 8 is now a clean miss (dirty line discarded) only if 0x014 was not rewritten; it was rewritten at entry 5 of the rerun, so the counts hold.
- Remain 100 cycles after DONE -> all counters unchanged (56/16/8).

Source files
------------

// File: rtl/cache_perf_top.sv
// Cache experiment top: a fixed request trace drives a direct-mapped write-back,
// write-allocate cache over a fixed-latency word memory; counts cycles, requests and hits.
module cache_perf_top #(
   parameter int MEM_LATENCY = 4,
   parameter int CACHE_LINES = 16,
   parameter int LINE_WORDS  = 4,
   parameter int MEM_WORDS   = 256,
   parameter int TRACE_LEN   = 16
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] clk_count,
   output logic [7:0] inst_count,
   output logic [7:0] hit_count
);
   localparam int OFF_W   = $clog2(LINE_WORDS);
   localparam int IDX_W   = $clog2(CACHE_LINES);
   localparam int TAG_LSB = 2 + OFF_W + IDX_W;
   localparam int TAG_W   = 32 - TAG_LSB;
   localparam int MEM_AW  = $clog2(MEM_WORDS);
   localparam int LINE_AW = MEM_AW - OFF_W;
   localparam int CNT_W   = $clog2(MEM_LATENCY + 1);
   localparam int PTR_W   = $clog2(TRACE_LEN + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOOKUP = 3'd1;
   localparam logic [2:0] S_WB     = 3'd2;
   localparam logic [2:0] S_REFILL = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   function automatic logic [MEM_WORDS-1:0][31:0] mem_image();
      logic [MEM_WORDS-1:0][31:0] img;
      for (int i = 0; i < MEM_WORDS; i++) img[i] = 32'(i * 4);
      return img;
   endfunction

   // {is_write, byte_address}
   function automatic logic [32:0] trace_at(input logic [3:0] i);
      logic [32:0] t;
      t = '0;
      case (i)
         4'd0:  t = {1'b0, 32'h000};
         4'd1:  t = {1'b0, 32'h004};
         4'd2:  t = {1'b0, 32'h008};
         4'd3:  t = {1'b0, 32'h00C};
         4'd4:  t = {1'b0, 32'h010};
         4'd5:  t = {1'b1, 32'h014};
         4'd6:  t = {1'b0, 32'h100};
         4'd7:  t = {1'b0, 32'h000};
         4'd8:  t = {1'b0, 32'h110};
         4'd9:  t = {1'b0, 32'h014};
         4'd10: t = {1'b0, 32'h018};
         4'd11: t = {1'b0, 32'h200};
         4'd12: t = {1'b0, 32'h204};
         4'd13: t = {1'b1, 32'h208};
         4'd14: t = {1'b0, 32'h208};
         4'd15: t = {1'b0, 32'h000};
      endcase
      return t;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [2:0]         state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         clk_cnt_q, clk_cnt_d, inst_cnt_q, inst_cnt_d, hit_cnt_q, hit_cnt_d;
   logic [CACHE_LINES-1:0] valid_q, dirty_q;
   logic [TAG_W-1:0]   tag_q [CACHE_LINES];
   logic [LINE_WORDS-1:0][31:0] data_q [CACHE_LINES];
   // Power-up image only; the backing store deliberately survives reset.
   logic [MEM_WORDS-1:0][31:0] mem_q = mem_image();
   logic               ld_vld_q, ld_vld_d;
   logic [31:0]        ld_dat_q, ld_dat_d;

   logic [32:0]        cur;
   logic               cur_wr, hit, done_req, was_hit, wb_en, fill_en, wr_hit_en;
   logic [31:0]        cur_addr, wdata;
   logic [IDX_W-1:0]   idx;
   logic [OFF_W-1:0]   off;
   logic [TAG_W-1:0]   tag;
   logic [LINE_AW-1:0] mem_line, victim_line;
   logic [LINE_WORDS-1:0][31:0] fill_line;

   assign cur         = trace_at(ptr_q[3:0]);
   assign cur_wr      = cur[32];
   assign cur_addr    = cur[31:0];
   assign idx         = cur_addr[TAG_LSB-1 -: IDX_W];
   assign off         = cur_addr[2 +: OFF_W];
   assign tag         = cur_addr[31 -: TAG_W];
   assign mem_line    = cur_addr[2+OFF_W +: LINE_AW];
   assign victim_line = {tag_q[idx][LINE_AW-IDX_W-1:0], idx};
   assign hit         = valid_q[idx] && (tag_q[idx] == tag);
   assign wdata       = 32'hA5A5_0000 | {16'h0, cur_addr[15:0]};

   always_comb begin
      for (int w = 0; w < LINE_WORDS; w++) begin
         fill_line[w] = mem_q[{mem_line, OFF_W'(w)}];
         if (cur_wr && off == OFF_W'(w)) fill_line[w] = wdata;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      clk_cnt_d  = (state_q != S_DONE) ? sat_inc(clk_cnt_q) : clk_cnt_q;
      inst_cnt_d = inst_cnt_q;
      hit_cnt_d  = hit_cnt_q;
      ld_vld_d   = 1'b0;
      ld_dat_d   = ld_dat_q;
      done_req   = 1'b0;
      was_hit    = 1'b0;
      wb_en      = 1'b0;
      fill_en    = 1'b0;
      wr_hit_en  = 1'b0;
      case (state_q)
         // IDLE performs the lookup of entry 0 so the first cycle is not wasted.
         S_IDLE, S_LOOKUP: begin
            if (hit) begin
               done_req  = 1'b1;
               was_hit   = 1'b1;
               wr_hit_en = cur_wr;
               ld_dat_d  = data_q[idx][off];
            end else begin
               cnt_d   = '0;
               state_d = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_REFILL;
            end
         end
         S_WB: begin
            if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
               wb_en   = 1'b1;
               cnt_d   = '0;
               state_d = S_REFILL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_REFILL: begin
            if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
               fill_en  = 1'b1;
               done_req = 1'b1;
               ld_dat_d = mem_q[{mem_line, off}];
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
      if (done_req) begin
         ld_vld_d   = !cur_wr;
         inst_cnt_d = sat_inc(inst_cnt_q);
         if (was_hit) hit_cnt_d = sat_inc(hit_cnt_q);
         ptr_d   = ptr_q + PTR_W'(1);
         state_d = (ptr_q == PTR_W'(TRACE_LEN - 1)) ? S_DONE : S_LOOKUP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         clk_cnt_q  <= '0;
         inst_cnt_q <= '0;
         hit_cnt_q  <= '0;
         valid_q    <= '0;
         dirty_q    <= '0;
         ld_vld_q   <= 1'b0;
         ld_dat_q   <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         clk_cnt_q  <= clk_cnt_d;
         inst_cnt_q <= inst_cnt_d;
         hit_cnt_q  <= hit_cnt_d;
         ld_vld_q   <= ld_vld_d;
         ld_dat_q   <= ld_dat_d;
         if (wr_hit_en) dirty_q[idx] <= 1'b1;
         if (fill_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= cur_wr;
         end
      end
   end

   // Arrays carry no reset; reset only suppresses their updates.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (wr_hit_en) data_q[idx][off] <= wdata;
         if (fill_en) begin
            data_q[idx] <= fill_line;
            tag_q[idx]  <= tag;
         end
         if (wb_en) begin
            for (int w = 0; w < LINE_WORDS; w++)
               mem_q[{victim_line, OFF_W'(w)}] <= data_q[idx][w];
         end
      end
   end

   assign clk_count  = clk_cnt_q;
   assign inst_count = inst_cnt_q;
   assign hit_count  = hit_cnt_q;
endmodule

// File: tb/tb_cache_perf_top.sv
// Bench for cache_perf_top: entry-level timing/cache model plus literal anchors,
// with randomized reset disturbances.
module tb_cache_perf_top;
   localparam int LAT = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] clk_count, inst_count, hit_count;

   cache_perf_top dut (
      .clk(clk),
      .rst(rst),
      .clk_count(clk_count),
      .inst_count(inst_count),
      .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   bit          t_wr   [16] = '{0,0,0,0, 0,1,0,0, 0,0,0,0, 0,1,0,0};
   int unsigned t_addr [16] = '{'h000,'h004,'h008,'h00C,'h010,'h014,'h100,'h000,
                                'h110,'h014,'h018,'h200,'h204,'h208,'h208,'h000};

   int unsigned m_mem [256];
   bit          m_valid [16];
   bit          m_dirty [16];
   int unsigned m_tag [16];
   int unsigned m_data [16][4];
   int          m_cc = 0, m_ic = 0, m_hc = 0, m_ptr = 0, m_el = 0, m_need = 0;
   bit          m_busy = 0, m_done = 0, m_hit = 0, m_wb = 0, m_ld_vld = 0, armed = 0;
   int unsigned m_ld_dat = 0;
   int unsigned m_rd [16];
   int unsigned dut_rd [16];

   function automatic int sat8(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic mem_chk(input string name);
      int bad = 0;
      for (int i = 0; i < 256; i++)
         if (dut.mem_q[i] !== m_mem[i]) bad++;
      chk(name, bad, 0);
   endtask

   task automatic final_chk(input string tag);
      chk({tag, "_clk_count"}, clk_count, 56);
      chk({tag, "_inst_count"}, inst_count, 16);
      chk({tag, "_hit_count"}, hit_count, 8);
   endtask

   // Each request costs 1, 1+LAT or 1+2*LAT cycles; writeback commits at the end of its phase.
   always @(posedge clk) begin
      int unsigned a, idx, off, base;
      armed    = 1;
      m_ld_vld = 0;
      if (rst) begin
         m_cc = 0; m_ic = 0; m_hc = 0; m_ptr = 0; m_busy = 0; m_done = 0;
         for (int l = 0; l < 16; l++) begin
            m_valid[l] = 0;
            m_dirty[l] = 0;
         end
      end else if (!m_done) begin
         a   = t_addr[m_ptr];
         idx = (a >> 4) % 16;
         off = (a >> 2) % 4;
         if (!m_busy) begin
            m_hit  = m_valid[idx] && (m_tag[idx] == (a >> 8));
            m_wb   = !m_hit && m_valid[idx] && m_dirty[idx];
            m_need = m_hit ? 1 : (m_wb ? 1 + 2 * LAT : 1 + LAT);
            m_el   = 0;
            m_busy = 1;
         end
         m_el++;
         m_cc = sat8(m_cc);
         if (m_wb && m_el == 1 + LAT) begin
            base = ((m_tag[idx] * 256 + idx * 16) / 4) % 256;
            for (int w = 0; w < 4; w++) m_mem[base + w] = m_data[idx][w];
         end
         if (m_el == m_need) begin
            if (!m_hit) begin
               base = ((a / 16) * 4) % 256;
               for (int w = 0; w < 4; w++) m_data[idx][w] = m_mem[base + w];
               m_valid[idx] = 1;
               m_tag[idx]   = a >> 8;
               m_dirty[idx] = 0;
            end
            if (t_wr[m_ptr]) begin
               m_data[idx][off] = 32'hA5A5_0000 | (a & 32'hFFFF);
               m_dirty[idx]     = 1;
            end else begin
               m_ld_vld     = 1;
               m_ld_dat     = m_data[idx][off];
               m_rd[m_ptr]  = m_ld_dat;
            end
            m_ic = sat8(m_ic);
            if (m_hit) m_hc = sat8(m_hc);
            m_ptr++;
            m_busy = 0;
            m_done = (m_ptr == 16);
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("clk_count", clk_count, m_cc);
         chk("inst_count", inst_count, m_ic);
         chk("hit_count", hit_count, m_hc);
         chk("load_valid", {31'd0, dut.ld_vld_q}, {31'd0, m_ld_vld});
         if (m_ld_vld) chk("load_data", dut.ld_dat_q, m_ld_dat);
         if (dut.ld_vld_q && inst_count != 0) dut_rd[inst_count - 1] = dut.ld_dat_q;
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) m_mem[i] = i * 4;
      rst = 1;
      repeat (10) @(negedge clk);
      chk("reset_clk_count", clk_count, 0);
      chk("reset_inst_count", inst_count, 0);
      mem_chk("mem_untouched_in_reset");

      rst = 0;
      repeat (5) @(negedge clk);
      chk("inst_after_cycle5", inst_count, 1);
      repeat (3) @(negedge clk);
      chk("inst_after_cycle8", inst_count, 4);
      chk("hits_after_cycle8", hit_count, 3);
      repeat (24) @(negedge clk);
      chk("inst_after_cycle32", inst_count, 8);
      @(negedge clk);
      chk("inst_after_cycle33", inst_count, 9);
      chk("writeback_word_0x014", dut.mem_q[5], 32'hA5A5_0014);
      repeat (40) @(negedge clk);
      final_chk("run1");
      chk("entry9_data", dut_rd[9], 32'hA5A5_0014);
      chk("entry14_data", dut_rd[14], 32'hA5A5_0208);
      chk("entry10_data", dut_rd[10], 32'h0000_0018);
      chk("model_entry14", m_rd[14], 32'hA5A5_0208);
      chk("writeback_word_0x208", dut.mem_q[130], 32'hA5A5_0208);
      mem_chk("mem_run1");
      repeat (100) @(negedge clk);
      final_chk("after_done_idle");

      rst = 1;
      @(negedge clk);
      rst = 0;
      repeat (27) @(negedge clk);
      chk("inst_before_wb_abort", inst_count, 8);
      rst = 1;
      @(negedge clk);
      chk("abort_clk_count", clk_count, 0);
      chk("abort_hit_count", hit_count, 0);
      rst = 0;
      repeat (70) @(negedge clk);
      final_chk("rerun");
      mem_chk("mem_rerun");

      for (int k = 0; k < 6; k++) begin
         rst = 1;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         rst = 0;
         repeat ($urandom_range(1, 60)) @(negedge clk);
      end
      rst = 1;
      @(negedge clk);
      rst = 0;
      repeat (70) @(negedge clk);
      final_chk("random_tail");
      mem_chk("mem_random_tail");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
